// File: rtl/alu_seq.sv
// alu_seq: registered 6502-style ALU with multi-cycle BCD add/subtract, one digit per clock
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             dec,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             n,
    output logic             v,
    output logic             z,
    output logic             c,
    output logic             hc,
    output logic             err
);
    localparam int NIB = WIDTH / 4;
    localparam int IW = $clog2(NIB);

    typedef enum logic [1:0] {IDLE, EXEC, ADJ, DONE} state_t;

    state_t           state, state_nx;
    logic [3:0]       op_q;
    logic             dec_q, ci_q, k, v_bin, hc_d0;
    logic [WIDTH-1:0] a_q, b_q, bx, r, y_bcd;
    logic [WIDTH:0]   sum;
    logic [IW-1:0]    idx;
    logic             legal, arith, last, c_bin, v_b, hc_b, k_nx;
    logic [4:0]       s_add, s_sub;
    logic [3:0]       dig;

    assign ready = state == IDLE;
    assign done  = state == DONE;
    assign legal = op_q <= 4'd8;
    assign arith = op_q < 4'd2;
    assign bx    = op_q == 4'd1 ? ~b_q : b_q;
    assign sum   = {1'b0, a_q} + {1'b0, bx} + {{WIDTH{1'b0}}, ci_q};
    // carry out of bit 3 is the carry into bit 4
    assign hc_b  = a_q[4] ^ bx[4] ^ sum[4];
    assign v_b   = (a_q[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);

    always_comb begin
        r     = sum[WIDTH-1:0];
        c_bin = arith ? sum[WIDTH] : 1'b0;
        case (op_q)
            4'd2: r = a_q | b_q;
            4'd3: r = a_q ^ b_q;
            4'd4: r = a_q & b_q;
            4'd5: begin
                r     = {1'b0, a_q[WIDTH-1:1]};
                c_bin = a_q[0];
            end
            4'd6: begin
                r     = {a_q[WIDTH-2:0], 1'b0};
                c_bin = a_q[WIDTH-1];
            end
            4'd7: begin
                r     = {a_q[WIDTH-2:0], ci_q};
                c_bin = a_q[WIDTH-1];
            end
            4'd8: begin
                r     = {ci_q, a_q[WIDTH-1:1]};
                c_bin = a_q[0];
            end
            default: ;
        endcase
    end

    // digit ripple: a_q/b_q shift right one nibble per cycle, result digits enter a_q from the top
    assign s_add = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, k};
    assign s_sub = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0, ~k};
    assign k_nx  = op_q == 4'd0 ? s_add > 5'd9 : !s_sub[4];
    assign dig   = op_q == 4'd0 ? (s_add > 5'd9 ? s_add[3:0] - 4'd10 : s_add[3:0])
                                : (s_sub[4] ? s_sub[3:0] + 4'd10 : s_sub[3:0]);
    assign y_bcd = {dig, a_q[WIDTH-1:4]};
    assign last  = idx == IW'(NIB - 1);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? EXEC : IDLE;
            EXEC:    state_nx = dec_q && arith ? ADJ : DONE;
            ADJ:     state_nx = last ? DONE : ADJ;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            dec_q <= 1'b0;
            ci_q  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            k     <= 1'b0;
            v_bin <= 1'b0;
            hc_d0 <= 1'b0;
            idx   <= '0;
            y     <= '0;
            n     <= 1'b0;
            v     <= 1'b0;
            z     <= 1'b0;
            c     <= 1'b0;
            hc    <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q  <= op;
                    dec_q <= dec;
                    ci_q  <= ci;
                    a_q   <= a;
                    b_q   <= b;
                    err   <= 1'b0;
                    idx   <= '0;
                end
                EXEC: if (!legal) begin
                    err <= 1'b1;
                end else if (dec_q && arith) begin
                    k     <= ci_q;
                    v_bin <= v_b;
                end else begin
                    y  <= r;
                    n  <= r[WIDTH-1];
                    z  <= r == '0;
                    c  <= c_bin;
                    v  <= arith ? v_b : 1'b0;
                    hc <= arith ? hc_b : 1'b0;
                end
                ADJ: begin
                    a_q <= y_bcd;
                    b_q <= {4'b0, b_q[WIDTH-1:4]};
                    k   <= k_nx;
                    idx <= idx + IW'(1);
                    if (idx == '0) hc_d0 <= k_nx;
                    if (last) begin
                        y  <= y_bcd;
                        n  <= dig[3];
                        z  <= y_bcd == '0;
                        c  <= k_nx;
                        v  <= v_bin;
                        hc <= hc_d0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
